trig_pulse_shrink: RTL and testbench

TRIG_PULSE_SHRINK -- requirements
Module: trig_pulse_shrink

---
 rtl/sde_trigger_pkg.sv | 18 +
 rtl/rise_detect.sv | 27 ++
 rtl/trig_pulse_shrink.sv | 174 +++++++++++++++++
 tb/tb_trig_pulse_shrink.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sde_trigger_pkg.sv
// Shared trigger-path definitions: qualifier state encoding, drop counter width
// and a saturating increment for the drop counter.
package sde_trigger_pkg;

  localparam int unsigned DropW = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StQual = 2'd1,
    StHigh = 2'd2,
    StDead = 2'd3
  } trig_state_e;

  function automatic logic [DropW-1:0] sat_inc_drop(input logic [DropW-1:0] v);
    return (&v) ? v : v + DropW'(1);
  endfunction

endpackage

// File: rtl/rise_detect.sv
// rise_detect: registers the trigger level once and flags its low-to-high edge.
// Both stages reset high so a level already high at reset release is not an edge.
module rise_detect (
  input  logic CLK,
  input  logic RST,
  input  logic IN,
  output logic LVL,
  output logic RISE
);

  logic lvl_q, prev_q;

  // Sample the level and keep the previous sample for edge detection.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lvl_q  <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      lvl_q  <= IN;
      prev_q <= lvl_q;
    end
  end

  assign LVL  = lvl_q;
  assign RISE = lvl_q & ~prev_q;

endmodule

// File: rtl/trig_pulse_shrink.sv
// trig_pulse_shrink: qualifies a stretched trigger level into a single-cycle pulse,
// holds off after the level falls and counts rejected rising edges.
// Width measurement (WIDTH/WIDTH_VLD) is built only when TRIG_SHRINK_WIDTH_MEAS_EN
// is defined; otherwise both outputs are tied low.
module trig_pulse_shrink
  import sde_trigger_pkg::*;
#(
  parameter int unsigned MIN_WID = 2,
  parameter int unsigned DEAD    = 8,
  parameter int unsigned WBITS   = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN,
  output logic             OUT,
  output logic             BUSY,
  output logic [WBITS-1:0] WIDTH,
  output logic             WIDTH_VLD,
  output logic [DropW-1:0] DROP_CNT
);

  localparam logic [7:0]  QualLast = 8'(MIN_WID);
  localparam int unsigned DeadM1   = (DEAD == 0) ? 0 : DEAD - 1;
  localparam logic [15:0] DeadLast = 16'(DeadM1);

  logic             lvl, rise;
  trig_state_e      state_q, state_d;
  logic [7:0]       qcnt_q, qcnt_d;
  logic [15:0]      dcnt_q, dcnt_d;
  logic [DropW-1:0] drop_q, drop_d;
  logic             hi_first_q, hi_first_d;
  logic             out_q, out_d;
  logic             busy_q, busy_d;

  rise_detect u_rise (
    .CLK  (CLK),
    .RST  (RST),
    .IN   (IN),
    .LVL  (lvl),
    .RISE (rise)
  );

  // State, counters and the "just entered HIGH" marker.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= StIdle;
      qcnt_q     <= '0;
      dcnt_q     <= '0;
      drop_q     <= '0;
      hi_first_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      qcnt_q     <= qcnt_d;
      dcnt_q     <= dcnt_d;
      drop_q     <= drop_d;
      hi_first_q <= hi_first_d;
    end
  end

  // Next-state: qualify the rising level, hold while high, then hold off.
  always_comb begin
    state_d    = state_q;
    qcnt_d     = qcnt_q;
    dcnt_d     = dcnt_q;
    drop_d     = drop_q;
    hi_first_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rise) begin
          if (MIN_WID <= 1) begin
            state_d    = StHigh;
            hi_first_d = 1'b1;
          end else begin
            state_d = StQual;
            qcnt_d  = 8'd1;
          end
        end
      end
      StQual: begin
        if (lvl) begin
          qcnt_d = qcnt_q + 8'd1;
          if (qcnt_d == QualLast) begin
            state_d    = StHigh;
            hi_first_d = 1'b1;
          end
        end else begin
          state_d = StIdle;
          qcnt_d  = '0;
          drop_d  = sat_inc_drop(drop_q);
        end
      end
      StHigh: begin
        if (!lvl) begin
          dcnt_d  = '0;
          state_d = (DEAD == 0) ? StIdle : StDead;
        end
      end
      StDead: begin
        // Edges during holdoff are discarded but counted.
        if (rise) drop_d = sat_inc_drop(drop_q);
        if (dcnt_q == DeadLast) begin
          state_d = StIdle;
          dcnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: one pulse on the first HIGH cycle; BUSY follows the state.
  always_comb begin
    out_d  = (state_q == StHigh) && hi_first_q;
    busy_d = (state_d != StIdle);
  end

  // Register the pulse and busy flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      busy_q <= busy_d;
    end
  end

  assign OUT      = out_q;
  assign BUSY     = busy_q;
  assign DROP_CNT = drop_q;

`ifdef TRIG_SHRINK_WIDTH_MEAS_EN
  logic [WBITS-1:0] wcnt_q, wcnt_d;
  logic [WBITS-1:0] width_q, width_d;
  logic             vld_q, vld_d;

  // Width count starts at 1 on the accepted edge and saturates.
  always_comb begin
    wcnt_d = wcnt_q;
    if (state_q == StIdle && rise) begin
      wcnt_d = WBITS'(1);
    end else if ((state_q == StQual || state_q == StHigh) && lvl && !(&wcnt_q)) begin
      wcnt_d = wcnt_q + WBITS'(1);
    end
  end

  // Publish the width when the level drops out of HIGH; otherwise hold it.
  always_comb begin
    vld_d   = (state_q == StHigh) && !lvl;
    width_d = vld_d ? wcnt_q : width_q;
  end

  // Width measurement registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wcnt_q  <= '0;
      width_q <= '0;
      vld_q   <= 1'b0;
    end else begin
      wcnt_q  <= wcnt_d;
      width_q <= width_d;
      vld_q   <= vld_d;
    end
  end

  assign WIDTH     = width_q;
  assign WIDTH_VLD = vld_q;
`else
  assign WIDTH     = '0;
  assign WIDTH_VLD = 1'b0;
`endif

endmodule

// File: tb/tb_trig_pulse_shrink.sv
// Bench for trig_pulse_shrink: three instances (defaults, WBITS=3, MIN_WID=1/DEAD=0).
// Expected OUT cycles and WIDTH values are queued when stimulus is driven and
// popped by a negedge monitor when the DUT strobes.
module tb_trig_pulse_shrink;

`ifdef TRIG_SHRINK_WIDTH_MEAS_EN
  localparam bit MeasEn = 1'b1;
`else
  localparam bit MeasEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] in_v;

  logic       out0, out1, out2;
  logic       busy0, busy1, busy2;
  logic [7:0] wid0;
  logic [2:0] wid1;
  logic [7:0] wid2;
  logic       vld0, vld1, vld2;
  logic [7:0] drop0, drop1, drop2;

  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  int unsigned exp_out[3][$];
  int unsigned exp_wid[3][$];

  logic [2:0]  out_v, vld_v;
  int unsigned wid_v[3];
  int unsigned mon_e;

  trig_pulse_shrink u_dut0 (
    .CLK(clk), .RST(rst), .IN(in_v[0]), .OUT(out0), .BUSY(busy0),
    .WIDTH(wid0), .WIDTH_VLD(vld0), .DROP_CNT(drop0)
  );

  trig_pulse_shrink #(.WBITS(3)) u_dut1 (
    .CLK(clk), .RST(rst), .IN(in_v[1]), .OUT(out1), .BUSY(busy1),
    .WIDTH(wid1), .WIDTH_VLD(vld1), .DROP_CNT(drop1)
  );

  trig_pulse_shrink #(.MIN_WID(1), .DEAD(0)) u_dut2 (
    .CLK(clk), .RST(rst), .IN(in_v[2]), .OUT(out2), .BUSY(busy2),
    .WIDTH(wid2), .WIDTH_VLD(vld2), .DROP_CNT(drop2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    out_v    = {out2, out1, out0};
    vld_v    = {vld2, vld1, vld0};
    wid_v[0] = 32'(wid0);
    wid_v[1] = 32'(wid1);
    wid_v[2] = 32'(wid2);
  end

  // Scoreboard monitor: every OUT pulse and WIDTH_VLD strobe must match a queued entry.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (out_v[i]) begin
        total++;
        if (exp_out[i].size() == 0) begin
          bad++;
          $display("FAIL out%0d_unexpected: pulse at cycle %0d, required no pulse", i, cyc);
        end else begin
          mon_e = exp_out[i].pop_front();
          if (cyc !== mon_e) begin
            bad++;
            $display("FAIL out%0d_timing: pulse at cycle %0d, required cycle %0d", i, cyc, mon_e);
          end
        end
      end
      if (vld_v[i]) begin
        total++;
        if (exp_wid[i].size() == 0) begin
          bad++;
          $display("FAIL vld%0d_unexpected: strobe width=%0d at cycle %0d, required none",
                   i, wid_v[i], cyc);
        end else begin
          mon_e = exp_wid[i].pop_front();
          if (wid_v[i] !== mon_e) begin
            bad++;
            $display("FAIL width%0d: got %0d, required %0d", i, wid_v[i], mon_e);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic apply_reset();
    rst  = 1'b1;
    in_v = '0;
    for (int i = 0; i < 3; i++) begin
      exp_out[i].delete();
      exp_wid[i].delete();
    end
    idle(2);
    rst = 1'b0;
    idle(2);
  endtask

  task automatic check_queues(input int i, input string tag);
    total++;
    if (exp_out[i].size() != 0) begin
      bad++;
      $display("FAIL %s_out_missing: %0d pulses outstanding, required 0", tag, exp_out[i].size());
    end
    total++;
    if (exp_wid[i].size() != 0) begin
      bad++;
      $display("FAIL %s_vld_missing: %0d strobes outstanding, required 0", tag, exp_wid[i].size());
    end
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    in_v = '0;
    idle(3);
    total++; if (out0 !== 1'b0) begin bad++; $display("FAIL reset_out: got %b, required 0", out0); end
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b, required 0", busy0); end
    total++; if (wid0 !== 8'd0) begin bad++; $display("FAIL reset_width: got %0d, required 0", wid0); end
    total++; if (vld0 !== 1'b0) begin bad++; $display("FAIL reset_vld: got %b, required 0", vld0); end
    total++; if (drop0 !== 8'd0) begin bad++; $display("FAIL reset_drop: got %0d, required 0", drop0); end
    total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL reset_busy2: got %b, required 0", busy2); end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_basic();
    int unsigned e0;
    apply_reset();
    e0 = cyc + 1;
    exp_out[0].push_back(e0 + 3);
    if (MeasEn) exp_wid[0].push_back(5);
    in_v[0] = 1'b1;
    idle(5);
    in_v[0] = 1'b0;
    idle(18);
    total++; if (drop0 !== 8'd0) begin bad++; $display("FAIL basic_drop: got %0d, required 0", drop0); end
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL basic_busy: got %b, required 0", busy0); end
    total++;
    if (wid0 !== (MeasEn ? 8'd5 : 8'd0)) begin
      bad++; $display("FAIL basic_width_hold: got %0d, required %0d", wid0, MeasEn ? 5 : 0);
    end
    check_queues(0, "basic");
  endtask

  task automatic test_glitch();
    apply_reset();
    in_v[0] = 1'b1;
    step();
    in_v[0] = 1'b0;
    step();
    total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL glitch_busy_high: got %b, required 1", busy0); end
    step();
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL glitch_busy_low: got %b, required 0", busy0); end
    total++; if (drop0 !== 8'd1) begin bad++; $display("FAIL glitch_drop: got %0d, required 1", drop0); end
    idle(4);
    check_queues(0, "glitch");
  endtask

  task automatic test_dead();
    int unsigned e0;
    apply_reset();
    e0 = cyc + 1;
    exp_out[0].push_back(e0 + 3);
    if (MeasEn) exp_wid[0].push_back(4);
    in_v[0] = 1'b1; idle(4);
    in_v[0] = 1'b0; idle(2);
    in_v[0] = 1'b1; idle(4);
    total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL dead_busy: got %b, required 1", busy0); end
    in_v[0] = 1'b0;
    idle(16);
    total++; if (drop0 !== 8'd1) begin bad++; $display("FAIL dead_drop: got %0d, required 1", drop0); end
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL dead_idle: got %b, required 0", busy0); end
    check_queues(0, "dead");
  endtask

  task automatic test_sat();
    int unsigned e0;
    apply_reset();
    e0 = cyc + 1;
    exp_out[1].push_back(e0 + 3);
    if (MeasEn) exp_wid[1].push_back(7);
    in_v[1] = 1'b1; idle(20);
    in_v[1] = 1'b0; idle(14);
    total++;
    if (wid1 !== (MeasEn ? 3'd7 : 3'd0)) begin
      bad++; $display("FAIL sat_width: got %0d, required %0d", wid1, MeasEn ? 7 : 0);
    end
    total++; if (drop1 !== 8'd0) begin bad++; $display("FAIL sat_drop: got %0d, required 0", drop1); end
    check_queues(1, "sat");
  endtask

  task automatic test_reset_hold();
    apply_reset();
    rst  = 1'b1;
    in_v = 3'b111;
    idle(3);
    rst = 1'b0;
    idle(10);
    in_v = '0;
    idle(12);
    total++; if (drop0 !== 8'd0) begin bad++; $display("FAIL hold_drop0: got %0d, required 0", drop0); end
    total++; if (drop2 !== 8'd0) begin bad++; $display("FAIL hold_drop2: got %0d, required 0", drop2); end
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL hold_busy0: got %b, required 0", busy0); end
    total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL hold_busy2: got %b, required 0", busy2); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    in_v[0] = 1'b1;
    idle(3);
    rst = 1'b1;
    #1;
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL mid_busy_async: got %b, required 0", busy0); end
    total++; if (out0 !== 1'b0) begin bad++; $display("FAIL mid_out_async: got %b, required 0", out0); end
    idle(2);
    rst = 1'b0;
    idle(4);
    in_v[0] = 1'b0;
    idle(12);
    total++; if (drop0 !== 8'd0) begin bad++; $display("FAIL mid_drop: got %0d, required 0", drop0); end
    total++; if (wid0 !== 8'd0) begin bad++; $display("FAIL mid_width: got %0d, required 0", wid0); end
    check_queues(0, "mid");
  endtask

  task automatic test_min1();
    int unsigned e0;
    apply_reset();
    e0 = cyc + 1;
    exp_out[2].push_back(e0 + 2);
    exp_out[2].push_back(e0 + 4);
    if (MeasEn) begin
      exp_wid[2].push_back(1);
      exp_wid[2].push_back(1);
    end
    in_v[2] = 1'b1; step();
    in_v[2] = 1'b0; step();
    in_v[2] = 1'b1; step();
    in_v[2] = 1'b0;
    idle(6);
    total++; if (drop2 !== 8'd0) begin bad++; $display("FAIL min1_drop: got %0d, required 0", drop2); end
    total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL min1_busy: got %b, required 0", busy2); end
    total++;
    if (wid2 !== (MeasEn ? 8'd1 : 8'd0)) begin
      bad++; $display("FAIL min1_width: got %0d, required %0d", wid2, MeasEn ? 1 : 0);
    end
    check_queues(2, "min1");
  endtask

  task automatic test_drop_sat();
    apply_reset();
    for (int k = 0; k < 260; k++) begin
      in_v[0] = 1'b1; step();
      in_v[0] = 1'b0; step();
    end
    idle(4);
    total++; if (drop0 !== 8'd255) begin bad++; $display("FAIL drop_sat: got %0d, required 255", drop0); end
    check_queues(0, "dropsat");
  endtask

  initial begin
    rst  = 1'b1;
    in_v = '0;
    test_reset();
    test_basic();
    test_glitch();
    test_dead();
    test_sat();
    test_reset_hold();
    test_reset_mid();
    test_min1();
    test_drop_sat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
